// File: rtl/mem_block_ctrl_if.sv
// Request/response and word-RAM bus of the line-transfer memory controller.
// The controller takes the slave view; requester plus RAM take the master view.
interface mem_block_ctrl_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 12
);
  logic                             req_cs;
  logic                             req_rw;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [BLOCK_SIZE*WORD_WIDTH-1:0] req_data;
  logic                             res_ack;
  logic [BLOCK_SIZE*WORD_WIDTH-1:0] res_data;
  logic                             ram_en;
  logic                             ram_we;
  logic [RAM_ADDR_WIDTH-1:0]        ram_addr;
  logic [WORD_WIDTH-1:0]            ram_wdata;
  logic [WORD_WIDTH-1:0]            ram_rdata;

  modport slave (
    input  req_cs, req_rw, req_addr, req_data, ram_rdata,
    output res_ack, res_data, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_cs, req_rw, req_addr, req_data, ram_rdata,
    input  res_ack, res_data, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_block_ctrl.sv
// Moves one cache line per request as BLOCK_SIZE word accesses to a synchronous RAM.
// Ack after BLOCK_SIZE+1 (write) or BLOCK_SIZE+RAM_LATENCY+1 (read) cycles; req_cs must be held until ack.
module mem_block_ctrl #(
  parameter int WORD_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int RAM_LATENCY    = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_block_ctrl_if.slave  bus
);
  localparam int OB = $clog2(BLOCK_SIZE);
  localparam logic [OB:0]   BS_CNT   = (OB+1)'(BLOCK_SIZE);
  localparam logic [OB-1:0] LAST_OFF = OB'(BLOCK_SIZE-1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

  state_t                    state_q, state_d;
  logic [OB:0]               issue_q, issue_d;
  logic [OB-1:0]             cap_q, cap_d;
  logic [RAM_ADDR_WIDTH-1:0] base_q;
  logic [WORD_WIDTH-1:0]     wline_q [BLOCK_SIZE];
  logic [WORD_WIDTH-1:0]     rline_q [BLOCK_SIZE];
  logic [BLOCK_SIZE*WORD_WIDTH-1:0] res_data_q;
  logic [RAM_LATENCY-1:0]    vld_q;
  logic                      ram_en_q, ram_en_d;
  logic                      ram_we_q, ram_we_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
  logic                      res_ack_q, res_ack_d;
  logic                      accept, cap_en, cap_last;
  logic [RAM_ADDR_WIDTH-1:0] req_base, issue_addr;
  logic                      unused_addr;

  // Offset bits are forced to zero, so base + offset never carries out of the line.
  assign req_base    = {bus.req_addr[RAM_ADDR_WIDTH-1:OB], {OB{1'b0}}};
  assign issue_addr  = base_q + {{(RAM_ADDR_WIDTH-OB){1'b0}}, issue_q[OB-1:0]};
  assign unused_addr = ^bus.req_addr;

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    cap_d       = cap_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    res_ack_d   = 1'b0;
    accept      = 1'b0;
    cap_en      = 1'b0;
    cap_last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_cs) begin
          accept     = 1'b1;
          issue_d    = (OB+1)'(1);
          cap_d      = '0;
          ram_en_d   = 1'b1;
          ram_we_d   = bus.req_rw;
          ram_addr_d = req_base;
          if (bus.req_rw) ram_wdata_d = bus.req_data[WORD_WIDTH-1:0];
          state_d    = bus.req_rw ? WRITE : READ;
        end
      end
      WRITE: begin
        if (issue_q < BS_CNT) begin
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = issue_addr;
          ram_wdata_d = wline_q[issue_q[OB-1:0]];
          issue_d     = issue_q + 1'b1;
        end else begin
          res_ack_d = 1'b1;
          state_d   = ACK;
        end
      end
      READ: begin
        if (issue_q < BS_CNT) begin
          ram_en_d   = 1'b1;
          ram_addr_d = issue_addr;
          issue_d    = issue_q + 1'b1;
        end
        if (vld_q[RAM_LATENCY-1]) begin
          cap_en = 1'b1;
          cap_d  = cap_q + 1'b1;
          if (cap_q == LAST_OFF) begin
            cap_last  = 1'b1;
            res_ack_d = 1'b1;
            state_d   = ACK;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      cap_q       <= '0;
      base_q      <= '0;
      vld_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      res_ack_q   <= 1'b0;
      res_data_q  <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        wline_q[i] <= '0;
        rline_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      cap_q       <= cap_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      res_ack_q   <= res_ack_d;
      if (accept) begin
        base_q <= req_base;
        for (int i = 0; i < BLOCK_SIZE; i++)
          wline_q[i] <= bus.req_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
      // A token follows each read issue so capture lines up with RAM latency.
      vld_q[0] <= ram_en_q & ~ram_we_q;
      for (int k = 1; k < RAM_LATENCY; k++)
        vld_q[k] <= vld_q[k-1];
      if (cap_en) rline_q[cap_q] <= bus.ram_rdata;
      if (cap_last) begin
        for (int i = 0; i < BLOCK_SIZE; i++)
          res_data_q[i*WORD_WIDTH +: WORD_WIDTH] <= (OB'(i) == cap_q) ? bus.ram_rdata : rline_q[i];
      end
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.res_ack   = res_ack_q;
  assign bus.res_data  = res_data_q;
endmodule

// File: tb/tb_mem_block_ctrl.sv
// Bench for mem_block_ctrl: latency-1 and latency-3 instances, each with its own RAM model,
// checked against a queue of expected RAM operations and acks built from a shadow line model.
module tb_mem_block_ctrl;
  typedef struct { int cyc; logic we; logic [11:0] addr; logic [31:0] wdata; } op_t;
  typedef struct { int cyc; logic rd; logic [127:0] data; } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic         cs   [2];
  logic         rw   [2];
  logic [31:0]  addr [2];
  logic [127:0] data [2];
  logic         en_w [2];
  logic         we_w [2];
  logic [11:0]  addr_w [2];
  logic [31:0]  wdata_w [2];
  logic         ack_w [2];
  logic [127:0] res_w [2];

  op_t  op_q  [2][$];
  ack_t ack_q [2][$];
  logic [31:0] shadow [2][0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;
    mem_block_ctrl_if #(.WORD_WIDTH(32), .BLOCK_SIZE(4), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(12)) bus ();
    logic [31:0] mem  [0:4095];
    logic [31:0] pipe [LAT];

    assign bus.req_cs   = cs[g];
    assign bus.req_rw   = rw[g];
    assign bus.req_addr = addr[g];
    assign bus.req_data = data[g];
    assign en_w[g]      = bus.ram_en;
    assign we_w[g]      = bus.ram_we;
    assign addr_w[g]    = bus.ram_addr;
    assign wdata_w[g]   = bus.ram_wdata;
    assign ack_w[g]     = bus.res_ack;
    assign res_w[g]     = bus.res_data;
    assign bus.ram_rdata = pipe[LAT-1];

    mem_block_ctrl #(.WORD_WIDTH(32), .BLOCK_SIZE(4), .ADDR_WIDTH(32),
                     .RAM_ADDR_WIDTH(12), .RAM_LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    always @(posedge clk) begin
      if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_en && !bus.ram_we) pipe[0] <= mem[bus.ram_addr];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    always @(negedge clk) begin : mon
      op_t  e;
      ack_t a;
      if (!rst) begin
        if (bus.ram_en) begin
          total++;
          if (op_q[g].size() == 0) begin
            bad++;
            $display("FAIL ram_op_unexpected inst%0d cyc=%0d got addr=%h we=%b, required no access", g, cyc, bus.ram_addr, bus.ram_we);
          end else begin
            e = op_q[g].pop_front();
            if (cyc !== e.cyc || bus.ram_we !== e.we || bus.ram_addr !== e.addr || (e.we && bus.ram_wdata !== e.wdata)) begin
              bad++;
              $display("FAIL ram_op inst%0d got cyc=%0d we=%b addr=%h wdata=%h required cyc=%0d we=%b addr=%h wdata=%h",
                       g, cyc, bus.ram_we, bus.ram_addr, bus.ram_wdata, e.cyc, e.we, e.addr, e.wdata);
            end
          end
        end
        if (bus.res_ack) begin
          total++;
          if (ack_q[g].size() == 0) begin
            bad++;
            $display("FAIL ack_unexpected inst%0d cyc=%0d got ack, required none", g, cyc);
          end else begin
            a = ack_q[g].pop_front();
            if (cyc !== a.cyc || (a.rd && bus.res_data !== a.data)) begin
              bad++;
              $display("FAIL ack inst%0d got cyc=%0d data=%h required cyc=%0d data=%h", g, cyc, bus.res_data, a.cyc, a.data);
            end
          end
        end
      end
    end
  end

  task automatic expect_req(input int sel, input logic w, input logic [31:0] a, input logic [127:0] line, input int c);
    op_t  o;
    ack_t k;
    logic [11:0] base;
    base = a[11:0] & 12'hFFC;
    for (int i = 0; i < 4; i++) begin
      o.cyc = c + 1 + i;
      o.we = w;
      o.addr = base + 12'(i);
      o.wdata = line[i*32 +: 32];
      op_q[sel].push_back(o);
      if (w) shadow[sel][o.addr] = o.wdata;
    end
    k.cyc = c + 5 + (w ? 0 : (sel != 0 ? 3 : 1));
    k.rd = !w;
    for (int i = 0; i < 4; i++) k.data[i*32 +: 32] = shadow[sel][base + 12'(i)];
    ack_q[sel].push_back(k);
  endtask

  task automatic start(input int sel, input logic w, input logic [31:0] a, input logic [127:0] line, output int c);
    @(negedge clk);
    cs[sel] = 1'b1;
    rw[sel] = w;
    addr[sel] = a;
    data[sel] = line;
    c = cyc;
    expect_req(sel, w, a, line, c);
  endtask

  task automatic wait_ack(input int sel, output int acyc);
    bit seen = 0;
    acyc = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (ack_w[sel] === 1'b1) begin
        seen = 1;
        acyc = cyc;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_timeout inst%0d got no ack, required one within 40 cycles", sel);
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin
      cs[g] = 0; rw[g] = 0; addr[g] = 0; data[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({en_w[g], we_w[g], addr_w[g], wdata_w[g], ack_w[g]} !== 46'd0) begin
        bad++;
        $display("FAIL reset_ram inst%0d got en=%b we=%b addr=%h wdata=%h ack=%b required all 0", g, en_w[g], we_w[g], addr_w[g], wdata_w[g], ack_w[g]);
      end
      total++;
      if (res_w[g] !== 128'd0) begin
        bad++;
        $display("FAIL reset_res_data inst%0d got %h required 0", g, res_w[g]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    int c, a;
    logic [127:0] l1, l2;
    l1 = 128'h00000044_00000033_00000022_00000011;
    l2 = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
    start(0, 1'b1, 32'h40, l1, c);
    wait_ack(0, a);
    cs[0] = 0;
    total++;
    if (a - c !== 5) begin bad++; $display("FAIL write_latency got %0d required 5", a - c); end
    start(0, 1'b0, 32'h42, 128'd0, c);
    wait_ack(0, a);
    cs[0] = 0;
    total++;
    if (a - c !== 6 || res_w[0] !== l1) begin
      bad++;
      $display("FAIL unaligned_read got lat=%0d data=%h required lat=6 data=%h", a - c, res_w[0], l1);
    end
    start(0, 1'b1, 32'h100, l2, c);
    wait_ack(0, a);
    cs[0] = 0;
    @(negedge clk);
    total++;
    if (res_w[0] !== l1) begin bad++; $display("FAIL res_hold_after_write got %h required %h", res_w[0], l1); end
  endtask

  task automatic test_back_to_back();
    int c, a, b;
    logic [127:0] l3;
    l3 = 128'hCAFE0083_CAFE0082_CAFE0081_CAFE0080;
    start(0, 1'b1, 32'hABC0_0080, l3, c);
    wait_ack(0, a);
    rw[0] = 1'b0;
    addr[0] = 32'h80;
    data[0] = 128'd0;
    expect_req(0, 1'b0, 32'h80, 128'd0, a + 1);
    wait_ack(0, b);
    cs[0] = 0;
    total++;
    if (b - a !== 7 || res_w[0] !== l3) begin
      bad++;
      $display("FAIL back_to_back got gap=%0d data=%h required gap=7 data=%h", b - a, res_w[0], l3);
    end
  endtask

  task automatic test_reset_mid_read();
    int c, a;
    op_t o;
    bit quiet = 1;
    @(negedge clk);
    cs[0] = 1; rw[0] = 0; addr[0] = 32'h40;
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      o.cyc = c + 1 + i; o.we = 0; o.addr = 12'h40 + 12'(i); o.wdata = 0;
      op_q[0].push_back(o);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (en_w[0] !== 1'b0 || we_w[0] !== 1'b0 || ack_w[0] !== 1'b0 || res_w[0] !== 128'd0) begin
      bad++;
      $display("FAIL reset_mid_read got en=%b we=%b ack=%b data=%h required 0", en_w[0], we_w[0], ack_w[0], res_w[0]);
    end
    cs[0] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (en_w[0] !== 1'b0 || ack_w[0] !== 1'b0) quiet = 0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL post_reset_quiet got activity required none"); end
    start(0, 1'b0, 32'h40, 128'd0, c);
    wait_ack(0, a);
    cs[0] = 0;
    total++;
    if (a - c !== 6) begin bad++; $display("FAIL read_after_reset got lat=%0d required 6", a - c); end
  endtask

  task automatic test_latency3();
    int c, a;
    logic [127:0] l4;
    l4 = 128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001;
    start(1, 1'b1, 32'h40, l4, c);
    wait_ack(1, a);
    cs[1] = 0;
    start(1, 1'b0, 32'h40, 128'd0, c);
    wait_ack(1, a);
    cs[1] = 0;
    total++;
    if (a - c !== 8 || res_w[1] !== l4) begin
      bad++;
      $display("FAIL lat3_read got lat=%0d data=%h required lat=8 data=%h", a - c, res_w[1], l4);
    end
  endtask

  task automatic test_cs_drop();
    int c, a;
    bit quiet = 1;
    start(0, 1'b1, 32'hFC0, 128'h5555000D_5555000C_5555000B_5555000A, c);
    @(negedge clk);
    cs[0] = 0; rw[0] = 0; addr[0] = 32'h123; data[0] = {4{$urandom}};
    wait_ack(0, a);
    total++;
    if (a - c !== 5) begin bad++; $display("FAIL cs_drop_latency got %0d required 5", a - c); end
    repeat (8) begin
      @(negedge clk);
      if (en_w[0] !== 1'b0 || ack_w[0] !== 1'b0) quiet = 0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL cs_drop_idle got activity required none"); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_read();
    test_latency3();
    test_cs_drop();
    for (int g = 0; g < 2; g++) begin
      total++;
      if (op_q[g].size() != 0 || ack_q[g].size() != 0) begin
        bad++;
        $display("FAIL drain inst%0d got ops=%0d acks=%0d pending required 0", g, op_q[g].size(), ack_q[g].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_block_ctrl.md
Name: mem_block_ctrl

Overview:
- Block-transfer memory controller on the memory side of the data cache.
- Accepts one whole-line request at a time (read = line fill, write = write-back) and performs it as BLOCK_SIZE single-word accesses to a synchronous single-port word RAM.
- Completes each request with a one-cycle ack; read data is returned as a full line in the ack cycle.

Parameters:
- WORD_WIDTH, 32, bits per word.
- BLOCK_SIZE, 4, words per cache line; power of two, >= 2.
- ADDR_WIDTH, 32, width of word address on request side.
- RAM_ADDR_WIDTH, 12, RAM word-address width; RAM_ADDR_WIDTH > log2(BLOCK_SIZE).
- RAM_LATENCY, 1, cycles from RAM read issue to valid ram_rdata; 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_cs  in  1  request valid; requester holds it high until res_ack.
- req_rw  in  1  1 = write line, 0 = read line.
- req_addr  in  ADDR_WIDTH  word address of any word in the line.
- req_data  in  BLOCK_SIZE*WORD_WIDTH  write line; word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- res_ack  out  1  one-cycle completion pulse.
- res_data  out  BLOCK_SIZE*WORD_WIDTH  read line, same packing as req_data.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable; qualified by ram_en.
- ram_addr  out  RAM_ADDR_WIDTH  RAM word address.
- ram_wdata  out  WORD_WIDTH  RAM write data.
- ram_rdata  in  WORD_WIDTH  RAM read data, RAM_LATENCY cycles after a read issue.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset forces state IDLE, counters 0, res_ack 0, res_data 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0, and clears all latched request fields.
- Address: base = {req_addr[RAM_ADDR_WIDTH-1:OB], OB'b0} with OB = log2(BLOCK_SIZE). Offset bits of req_addr are ignored, so an unaligned address selects its line. Bits above RAM_ADDR_WIDTH are ignored, so addresses alias.
- FSM states: IDLE, WRITE, READ, ACK.
- IDLE:
  - If req_cs = 1 at the edge: latch base, req_rw and req_data; clear issue and capture counters; go to WRITE (rw = 1) or READ (rw = 0).
  - Otherwise stay in IDLE with ram_en = 0.
- WRITE:
  - Each cycle drives ram_en = 1, ram_we = 1, ram_addr = base + issue_cnt, ram_wdata = latched word[issue_cnt].
  - issue_cnt increments each cycle.
  - After word BLOCK_SIZE-1 is issued, go to ACK.
- READ:
  - Issue phase: while issue_cnt < BLOCK_SIZE, drive ram_en = 1, ram_we = 0, ram_addr = base + issue_cnt.
  - A RAM_LATENCY-deep valid shift register tracks issued reads.
  - When a token emerges, capture ram_rdata into line buffer word[cap_cnt], then increment cap_cnt.
  - Go to ACK on the edge where word BLOCK_SIZE-1 is captured.
  - ram_en = 0 while waiting for the remaining captures.
- ACK:
  - res_ack = 1 for exactly one cycle, then return to IDLE.
  - req_cs is not sampled in ACK.
- res_data: registered copy of the line buffer, updated only at read completion so it is valid in the ack cycle. It holds its value until the next read completes; write requests leave it unchanged.
- Latency, with cs sampled at edge 0:
  - Write: RAM writes in cycles 1..BLOCK_SIZE; res_ack in cycle BLOCK_SIZE+1.
  - Read: issues in cycles 1..BLOCK_SIZE; res_ack in cycle BLOCK_SIZE+RAM_LATENCY+1.
- Back-to-back: a request present in the cycle after ACK is accepted; minimum gap between acks is BLOCK_SIZE+2 cycles.
- Once latched, a request always completes, even if req_cs, req_rw, req_addr or req_data change or drop mid-transfer. Exactly one ack per accepted request.
- Arithmetic: base + issue_cnt never carries out of the line, since offset bits start at zero.
- Reset mid-transfer:
  - ram_en and ram_we drop immediately (asynchronous); no ack is produced.
  - Partial RAM writes already performed remain in RAM.
  - Captured partial read data is discarded.
- RAM outputs are registered; no combinational path from req_* to ram_* or res_*.

Test Plan:
1. BLOCK_SIZE=4, RAM_LATENCY=1; write req_addr=0x40, words {0x11,0x22,0x33,0x44} -> RAM writes at 0x40..0x43 in cycles 1-4 with matching data; res_ack only in cycle 5.
2. Then read req_addr=0x42 (unaligned) -> reads 0x40..0x43 in cycles 1-4; res_ack in cycle 6 with res_data words {0x11,0x22,0x33,0x44}; res_data unchanged by a subsequent write.
3. Write 0x80 with req_cs held high through ack, then read 0x80 presented in the following cycle -> one ack for the write; read accepted the cycle after ACK; second ack returns the written line.
4. Assert rst during READ cycle 2 -> ram_en = 0 the same cycle, no res_ack, res_data = 0; after release, a read of 0x40 completes normally in 6 cycles.
5. RAM_LATENCY=3 instance; read 0x40 -> ram_en high cycles 1-4 only; res_ack in cycle 8 with correct line.
6. req_cs dropped to 0 after edge 0 of a write to 0xFC0 -> all 4 writes still issued; single res_ack in cycle 5; IDLE afterwards with no further RAM activity.
